// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requests feeding a prefetch queue, with branch/jump redirect.
// Optional performance counters are enabled by defining FETCH_UNIT_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2     // 2, 4 or 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] instr_pc,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WAIT_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q [QDEPTH];
    logic [31:0]        pc_q   [QDEPTH];

    logic               redirect;
    logic [31:0]        target;
    logic               issue;
    logic               push;
    logic               pop;
    logic               flush;

    assign redirect = jump | pcsrc;
    assign target   = (jump ? jump_target : branch_target) & ~32'h0000_0003;
    assign pop      = instr_valid & instr_ready;

    // State and queue-control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and request issue; IDLE implies nothing outstanding, so occupancy alone gates issue
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        issue      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    flush      = 1'b1;
                end else if (!reset && (cnt_q < CNT_W'(QDEPTH))) begin
                    issue      = 1'b1;
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    flush      = 1'b1;
                    state_d    = imem_valid ? S_IDLE : S_WAIT_FLUSH;
                end else if (imem_valid) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_FLUSH: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end
                if (imem_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue pointers; a flush overrides any same-cycle pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (cnt_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

`ifdef FETCH_UNIT_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop)      fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (redirect) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected requests/instructions, negedge monitors compare.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        imem_req, imem_valid, instr_valid, instr_ready, pcsrc, jump;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, branch_target, jump_target;
    logic [5:0]  opcode, funct;
    logic [15:0] fetch_count, flush_count;

    logic        imem_req2, imem_valid2, instr_valid2;
    logic [31:0] imem_addr2, imem_rdata2, instr2, instr_pc2;
    logic [5:0]  opcode2, funct2;
    logic [15:0] fetch_count2, flush_count2;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] exp_req_q[$];
    exp_t        exp_ins_q[$];
    logic [31:0] exp_req2_q[$];
    logic [31:0] exp_pc2_q[$];

    logic        rq_seen = 1'b0, rq2_seen = 1'b0;
    logic [31:0] rq_addr = '0, rq2_addr = '0;
    logic        mem_auto = 1'b1;
    int          mem_lat = 1;

    fetch_unit u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcode        (opcode),
        .funct         (funct),
        .instr_pc      (instr_pc),
        .pcsrc         (pcsrc),
        .jump          (jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_valid    (imem_valid2),
        .imem_rdata    (imem_rdata2),
        .instr_valid   (instr_valid2),
        .instr_ready   (1'b1),
        .instr         (instr2),
        .opcode        (opcode2),
        .funct         (funct2),
        .instr_pc      (instr_pc2),
        .pcsrc         (1'b0),
        .jump          (1'b0),
        .branch_target (32'h0),
        .jump_target   (32'h0),
        .fetch_count   (fetch_count2),
        .flush_count   (flush_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] perf(input int n);
`ifdef FETCH_UNIT_PERF_EN
        return 32'(n);
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Monitors: compare requests and consumed instructions against the scoreboard queues
    always @(negedge clk) begin
        rq_seen  = imem_req && !reset;
        rq_addr  = imem_addr;
        rq2_seen = imem_req2 && !reset;
        rq2_addr = imem_addr2;
        if (!reset) begin
            if (imem_req && exp_req_q.size() != 0) begin
                logic [31:0] a;
                a = exp_req_q.pop_front();
                check("req_addr", imem_addr, a);
            end
            if (instr_valid && instr_ready && exp_ins_q.size() != 0) begin
                exp_t e;
                logic [31:0] w;
                e = exp_ins_q.pop_front();
                w = e.ins;
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, w);
                check("opcode", 32'(opcode), 32'(w[31:26]));
                check("funct", 32'(funct), 32'(w[5:0]));
            end
            if (imem_req2 && exp_req2_q.size() != 0) begin
                logic [31:0] a2;
                a2 = exp_req2_q.pop_front();
                check("wrap_req_addr", imem_addr2, a2);
            end
            if (instr_valid2 && exp_pc2_q.size() != 0) begin
                logic [31:0] p2;
                p2 = exp_pc2_q.pop_front();
                check("wrap_instr_pc", instr_pc2, p2);
                check("wrap_instr", instr2, ~p2);
            end
        end
    end

    // Memory model for the main DUT: one request at a time, response mem_lat cycles later, data = ~addr
    initial begin
        logic        busy;
        int          cnt;
        logic [31:0] addr;
        busy = 1'b0;
        cnt = 0;
        addr = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                imem_valid = 1'b0;
                if (reset) begin
                    busy = 1'b0;
                end else begin
                    if (rq_seen) begin
                        busy = 1'b1;
                        addr = rq_addr;
                        cnt  = mem_lat;
                    end
                    if (busy) begin
                        cnt--;
                        if (cnt == 0) begin
                            imem_valid = 1'b1;
                            imem_rdata = ~addr;
                            busy = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Memory model for the wrap DUT: fixed one-cycle latency
    initial begin
        imem_valid2 = 1'b0;
        imem_rdata2 = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_valid2 = rq2_seen;
            imem_rdata2 = ~rq2_addr;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_test(input int lat, input logic rdy);
        reset = 1'b1;
        pcsrc = 1'b0;
        jump  = 1'b0;
        cycles(2);
        exp_req_q.delete();
        exp_ins_q.delete();
        exp_req2_q.delete();
        exp_pc2_q.delete();
        mem_lat     = lat;
        instr_ready = rdy;
    endtask

    task automatic go();
        reset = 1'b0;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_0000);
    endtask

    task automatic drained(input string name);
        check({name, "_req_drained"}, 32'(exp_req_q.size()), 32'd0);
        check({name, "_ins_drained"}, 32'(exp_ins_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        instr_ready = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        branch_target = '0;
        jump_target = '0;
        cycles(3);

        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        check("rst_flush_count", 32'(flush_count), 32'd0);

        // Streaming, 1-cycle latency, decode always ready; wrap DUT runs alongside
        start_test(1, 1'b1);
        exp_req_q  = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_ins_q.push_back('{pc: 32'h0, ins: 32'hFFFF_FFFF});
        exp_ins_q.push_back('{pc: 32'h4, ins: 32'hFFFF_FFFB});
        exp_ins_q.push_back('{pc: 32'h8, ins: 32'hFFFF_FFF7});
        exp_ins_q.push_back('{pc: 32'hC, ins: 32'hFFFF_FFF3});
        exp_req2_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        exp_pc2_q  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        go();
        cycles(10);
        check("stream_fetch_count", 32'(fetch_count), perf(4));
        check("stream_flush_count", 32'(flush_count), perf(0));
        drained("stream");
        check("wrap_req_drained", 32'(exp_req2_q.size()), 32'd0);
        check("wrap_pc_drained", 32'(exp_pc2_q.size()), 32'd0);

        // Decode stalled: queue fills to depth 2, then requests stop and the head holds
        start_test(1, 1'b0);
        exp_req_q = '{32'h0, 32'h4, 32'h8};
        exp_ins_q.push_back('{pc: 32'h0, ins: 32'hFFFF_FFFF});
        exp_ins_q.push_back('{pc: 32'h4, ins: 32'hFFFF_FFFB});
        exp_ins_q.push_back('{pc: 32'h8, ins: 32'hFFFF_FFF7});
        go();
        cycles(4);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_no_req", 32'(imem_req), 32'd0);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_head", instr, 32'hFFFF_FFFF);
            cycles(1);
        end
        instr_ready = 1'b1;
        cycles(6);
        drained("stall");

        // Jump while a 3-cycle request is outstanding: stale response dropped
        start_test(3, 1'b1);
        exp_req_q = '{32'h0, 32'h400};
        exp_ins_q.push_back('{pc: 32'h400, ins: 32'hFFFF_FBFF});
        go();
        cycles(1);
        jump = 1'b1;
        jump_target = 32'h400;
        cycles(1);
        jump = 1'b0;
        #1;
        check("jwait_valid_after", 32'(instr_valid), 32'd0);
        check("jwait_no_req_c2", 32'(imem_req), 32'd0);
        cycles(1);
        #1;
        check("jwait_no_req_c3", 32'(imem_req), 32'd0);
        cycles(1);
        #1;
        check("jwait_req_c4", 32'(imem_req), 32'd1);
        check("jwait_addr_c4", imem_addr, 32'h400);
        cycles(5);
        check("jwait_fetch_count", 32'(fetch_count), perf(1));
        check("jwait_flush_count", 32'(flush_count), perf(1));
        drained("jwait");

        // Branch and jump together, coinciding with the response: jump wins, response dropped
        start_test(1, 1'b1);
        exp_req_q = '{32'h0, 32'h200};
        exp_ins_q.push_back('{pc: 32'h200, ins: 32'hFFFF_FDFF});
        go();
        cycles(1);
        pcsrc = 1'b1;
        jump = 1'b1;
        branch_target = 32'h100;
        jump_target = 32'h200;
        cycles(1);
        pcsrc = 1'b0;
        jump = 1'b0;
        #1;
        check("both_valid_after", 32'(instr_valid), 32'd0);
        check("both_req", 32'(imem_req), 32'd1);
        check("both_addr", imem_addr, 32'h200);
        cycles(3);
        check("both_fetch_count", 32'(fetch_count), perf(1));
        check("both_flush_count", 32'(flush_count), perf(1));
        drained("both");

        // Jump in IDLE with a same-cycle consumption; unaligned target gets its low bits cleared
        start_test(1, 1'b1);
        exp_req_q = '{32'h0, 32'h80};
        exp_ins_q.push_back('{pc: 32'h0, ins: 32'hFFFF_FFFF});
        exp_ins_q.push_back('{pc: 32'h80, ins: 32'hFFFF_FF7F});
        go();
        cycles(2);
        jump = 1'b1;
        jump_target = 32'h83;
        #1;
        check("idle_jump_head", 32'(instr_valid), 32'd1);
        check("idle_jump_no_req", 32'(imem_req), 32'd0);
        cycles(1);
        jump = 1'b0;
        #1;
        check("idle_jump_valid_after", 32'(instr_valid), 32'd0);
        check("idle_jump_req", 32'(imem_req), 32'd1);
        check("idle_jump_addr", imem_addr, 32'h80);
        cycles(3);
        check("idle_jump_fetch_count", 32'(fetch_count), perf(2));
        check("idle_jump_flush_count", 32'(flush_count), perf(1));
        drained("idle_jump");

        // Reset during WAIT with the response arriving just after: response ignored
        mem_auto = 1'b0;
        imem_valid = 1'b0;
        start_test(1, 1'b1);
        exp_req_q = '{32'h0, 32'h0};
        go();
        cycles(1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rstwait_req", 32'(imem_req), 32'd1);
        check("rstwait_addr", imem_addr, 32'h0);
        cycles(1);
        imem_valid = 1'b0;
        #1;
        check("rstwait_not_queued", 32'(instr_valid), 32'd0);
        cycles(2);
        check("rstwait_still_empty", 32'(instr_valid), 32'd0);
        drained("rstwait");
        mem_auto = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
